// File: rtl/fir_hls_mul_pipe_if.sv
// Operand/result handshake bundle for one FIR lane multiplier.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready valid-ready pairs carried through the bundle.
interface fir_hls_mul_pipe_if #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 10,
    parameter int DOUT_WIDTH = 25
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [DIN0_WIDTH-1:0] din0;
    logic signed [DIN1_WIDTH-1:0] din1;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [DOUT_WIDTH-1:0] dout;
    logic                         ovf;
    logic                         ovf_clr;

    // Producer/consumer side (tap fetch + accumulator)
    modport master (
        output in_valid, din0, din1, out_ready, ovf_clr,
        input  in_ready, out_valid, dout, ovf
    );

    // Multiplier side
    modport slave (
        input  in_valid, din0, din1, out_ready, ovf_clr,
        output in_ready, out_valid, dout, ovf
    );
endinterface

// File: rtl/fir_hls_mul_pipe.sv
// Pipelined signed sample x coefficient multiplier with scaling, saturation and sticky overflow.
// Latency: NUM_STAGE cycles from input transfer to out_valid; 1 result per cycle.
// Backpressure: whole pipe stalls when out_valid & ~out_ready; in_ready is combinational from out_ready.
module fir_hls_mul_pipe #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 10,
    parameter int DOUT_WIDTH = 25,
    parameter int NUM_STAGE  = 2,
    parameter int SHIFT      = 0,
    parameter int ROUND_EN   = 0,
    parameter int SAT_EN     = 0
) (
    input logic                ap_clk,
    input logic                ap_rst_n,
    fir_hls_mul_pipe_if.slave  bus
);
    localparam int PW     = DIN0_WIDTH + DIN1_WIDTH;
    // Result is carried at least one bit wider than dout so range checks see the true value
    localparam int RW     = (PW + 1 > DOUT_WIDTH) ? PW + 1 : DOUT_WIDTH;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [PW:0] RND =
        (ROUND_EN != 0 && SHIFT > 0) ? ((PW+1)'(1) << RND_SH) : '0;

    logic                         adv;
    logic                         out_valid_q;
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic signed [DOUT_WIDTH-1:0] dout_d;
    logic                         ovf_q;
    logic                         ovf_d;
    logic signed [PW-1:0]         prod_in;
    logic signed [PW-1:0]         fin_p;
    logic                         fin_vld;
    logic signed [PW:0]           sum;
    logic signed [PW:0]           shr;
    logic signed [RW-1:0]         r_ext;
    logic                         rng_ovf;

    // The pipe moves as a whole whenever the output slot is free or being drained
    assign adv          = bus.out_ready | ~out_valid_q;
    assign bus.in_ready = adv;

    // Exact signed product: both operands sign-extended to the full product width
    assign prod_in = PW'(bus.din0) * PW'(bus.din1);

    if (NUM_STAGE == 1) begin : g_direct
        // Single stage: product and scaling both feed the output register directly
        assign fin_p   = prod_in;
        assign fin_vld = bus.in_valid;
    end else begin : g_pipe
        logic [NUM_STAGE-2:0] v_q;
        logic signed [PW-1:0] p_q [NUM_STAGE-1];

        // Stage valid bits: product register first, then pure delay stages
        always_ff @(posedge ap_clk) begin
            if (!ap_rst_n) begin
                v_q <= '0;
            end else if (adv) begin
                v_q[0] <= bus.in_valid;
                for (int k = 1; k < NUM_STAGE - 1; k++) begin
                    v_q[k] <= v_q[k-1];
                end
            end
        end

        // Stage data: no reset needed, qualified by the valid bits above
        always_ff @(posedge ap_clk) begin
            if (adv) begin
                p_q[0] <= prod_in;
                for (int k = 1; k < NUM_STAGE - 1; k++) begin
                    p_q[k] <= p_q[k-1];
                end
            end
        end

        assign fin_p   = p_q[NUM_STAGE-2];
        assign fin_vld = v_q[NUM_STAGE-2];
    end

    // Rounding add on a guard-bit-extended product, so it can never wrap
    assign sum   = {fin_p[PW-1], fin_p} + RND;
    assign shr   = sum >>> SHIFT;
    assign r_ext = RW'(shr);

    // Out of range when the bits above the dout sign bit are not all copies of it
    assign rng_ovf = !((&r_ext[RW-1:DOUT_WIDTH-1]) || !(|r_ext[RW-1:DOUT_WIDTH-1]));

    // Wrap by default; clamp to the signed extremes when saturation is enabled
    always_comb begin
        dout_d = r_ext[DOUT_WIDTH-1:0];
        if (SAT_EN != 0 && rng_ovf) begin
            dout_d = r_ext[RW-1] ? {1'b1, {(DOUT_WIDTH-1){1'b0}}}
                                 : {1'b0, {(DOUT_WIDTH-1){1'b1}}};
        end
    end

    // Sticky overflow: a new overflow landing this edge beats a clear request
    always_comb begin
        ovf_d = ovf_q;
        if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (adv && fin_vld && rng_ovf) begin
            ovf_d = 1'b1;
        end
    end

    // Output stage: dout only loads with a valid result and otherwise holds
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            if (adv) begin
                out_valid_q <= fin_vld;
                if (fin_vld) begin
                    dout_q <= dout_d;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_fir_hls_mul_pipe.sv
// Directed bench for the pipelined FIR multiplier across several parameter sets.
// All instances share one stimulus stream; each is checked against hand-computed values.
// A randomised sweep checks the 1-stage and 4-stage builds against a wrap model.
module tb_fir_hls_mul_pipe;
    localparam int N_RAND = 1000;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               out_ready;
    logic               ovf_clr;
    logic signed [15:0] din0;
    logic signed [9:0]  din1;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fir_hls_mul_pipe_if if_def ();
    fir_hls_mul_pipe_if if_sat ();
    fir_hls_mul_pipe_if if_tr  ();
    fir_hls_mul_pipe_if if_rn  ();
    fir_hls_mul_pipe_if if_s1  ();
    fir_hls_mul_pipe_if if_s4  ();

    assign {if_def.in_valid, if_def.din0, if_def.din1, if_def.out_ready, if_def.ovf_clr} = {in_valid, din0, din1, out_ready, ovf_clr};
    assign {if_sat.in_valid, if_sat.din0, if_sat.din1, if_sat.out_ready, if_sat.ovf_clr} = {in_valid, din0, din1, out_ready, ovf_clr};
    assign {if_tr.in_valid,  if_tr.din0,  if_tr.din1,  if_tr.out_ready,  if_tr.ovf_clr}  = {in_valid, din0, din1, out_ready, ovf_clr};
    assign {if_rn.in_valid,  if_rn.din0,  if_rn.din1,  if_rn.out_ready,  if_rn.ovf_clr}  = {in_valid, din0, din1, out_ready, ovf_clr};
    assign {if_s1.in_valid,  if_s1.din0,  if_s1.din1,  if_s1.out_ready,  if_s1.ovf_clr}  = {in_valid, din0, din1, out_ready, ovf_clr};
    assign {if_s4.in_valid,  if_s4.din0,  if_s4.din1,  if_s4.out_ready,  if_s4.ovf_clr}  = {in_valid, din0, din1, out_ready, ovf_clr};

    fir_hls_mul_pipe u_def (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if_def));
    fir_hls_mul_pipe #(.SAT_EN(1)) u_sat (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if_sat));
    fir_hls_mul_pipe #(.SHIFT(4), .ROUND_EN(0)) u_tr (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if_tr));
    fir_hls_mul_pipe #(.SHIFT(4), .ROUND_EN(1)) u_rn (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if_rn));
    fir_hls_mul_pipe #(.NUM_STAGE(1)) u_s1 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if_s1));
    fir_hls_mul_pipe #(.NUM_STAGE(4)) u_s4 (.ap_clk(clk), .ap_rst_n(rst_n), .bus(if_s4));

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b);
        din0     = a[15:0];
        din1     = b[9:0];
        in_valid = 1'b1;
    endtask

    // Reference: exact product folded modulo 2^25 into the signed 25-bit range
    function automatic longint mdl(input longint a, input longint b);
        longint r;
        r = a * b;
        r = r & ((64'sd1 <<< 25) - 1);
        if (r >= (64'sd1 <<< 24)) r = r - (64'sd1 <<< 25);
        return r;
    endfunction

    int sa  [3] = '{100, -100, -8};
    int sb  [3] = '{3, 3, 1};
    int etr [3] = '{18, -19, -1};
    int ern [3] = '{19, -19, 0};
    int ra [N_RAND];
    int rb [N_RAND];

    initial begin
        in_valid  = 1'b0;
        din0      = '0;
        din1      = '0;
        out_ready = 1'b1;
        ovf_clr   = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        check("rst_vld",  if_def.out_valid, 0);
        check("rst_dout", if_def.dout, 0);
        check("rst_ovf",  if_def.ovf, 0);
        check("rst_rdy",  if_def.in_ready, 1);
        rst_n = 1'b1;

        // Basic stream: 1000*-3 then 7*5
        drive(1000, -3);
        tick();
        check("s1_vld0", if_s1.out_valid, 1);
        check("s1_d0",   if_s1.dout, -3000);
        check("def_early", if_def.out_valid, 0);
        drive(7, 5);
        tick();
        check("def_vld0", if_def.out_valid, 1);
        check("def_d0",   if_def.dout, -3000);
        check("tr_d0",    if_tr.dout, -188);
        check("rn_d0",    if_rn.dout, -187);
        check("s1_d1",    if_s1.dout, 35);
        in_valid = 1'b0;
        tick();
        check("def_d1",  if_def.dout, 35);
        check("def_ovf", if_def.ovf, 0);
        check("tr_d1",   if_tr.dout, 2);
        check("rn_d1",   if_rn.dout, 2);
        check("s4_early", if_s4.out_valid, 0);
        tick();
        check("def_bubble", if_def.out_valid, 0);
        check("s4_vld0", if_s4.out_valid, 1);
        check("s4_d0",   if_s4.dout, -3000);
        tick();
        check("s4_d1",   if_s4.dout, 35);
        tick();

        // Full-scale negative x negative overflows 25 bits by one
        drive(-32768, -512);
        tick();
        in_valid = 1'b0;
        tick();
        check("wrap_d",   if_def.dout, -16777216);
        check("wrap_ovf", if_def.ovf, 1);
        check("sat_d",    if_sat.dout, 16777215);
        check("sat_ovf",  if_sat.ovf, 1);
        check("tr_big",   if_tr.dout, 1048576);
        check("tr_noovf", if_tr.ovf, 0);
        check("rn_big",   if_rn.dout, 1048576);
        tick();
        tick();
        tick();
        check("ovf_sticky", if_def.ovf, 1);
        check("s4_ovf",     if_s4.ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("clr_def", if_def.ovf, 0);
        check("clr_sat", if_sat.ovf, 0);
        check("clr_s4",  if_s4.ovf, 0);

        // Clear in the same cycle a new overflow lands: set must win
        drive(-32768, -512);
        tick();
        in_valid = 1'b0;
        ovf_clr  = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("set_wins", if_def.ovf, 1);
        check("clr_only", if_s1.ovf, 0);
        tick();
        tick();
        tick();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // Shift by 4: truncate vs round-half-up
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(sa[i], sb[i]);
            else       in_valid = 1'b0;
            tick();
            if (i >= 1) begin
                check($sformatf("tr_vld%0d", i-1), if_tr.out_valid, 1);
                check($sformatf("tr_sh%0d", i-1),  if_tr.dout, etr[i-1]);
                check($sformatf("rn_sh%0d", i-1),  if_rn.dout, ern[i-1]);
            end
        end
        tick();

        // Backpressure: 3-cycle stall right after the first result
        drive(1, 1);
        tick();
        drive(2, -3);
        tick();
        check("bp_first", if_def.dout, 1);
        out_ready = 1'b0;
        drive(-4, 5);
        #1;
        check("bp_rdy_comb", if_def.in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("bp_vld%0d", k),  if_def.out_valid, 1);
            check($sformatf("bp_hold%0d", k), if_def.dout, 1);
            check($sformatf("bp_rdy%0d", k),  if_def.in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_r1", if_def.dout, -6);
        drive(100, 100);
        tick();
        check("bp_r2", if_def.dout, -20);
        in_valid = 1'b0;
        tick();
        check("bp_r3", if_def.dout, 10000);
        tick();
        check("bp_drained", if_def.out_valid, 0);

        // Reset with results in flight: nothing stale may come out afterwards
        drive(-32768, -512);
        tick();
        drive(3, 3);
        tick();
        check("pre_rst_ovf", if_def.ovf, 1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mid_rst_vld", if_def.out_valid, 0);
        check("mid_rst_ovf", if_def.ovf, 0);
        check("mid_rst_rdy", if_def.in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("no_stale_def%0d", k), if_def.out_valid, 0);
            check($sformatf("no_stale_s4_%0d", k), if_s4.out_valid, 0);
        end
        drive(2, 2);
        tick();
        in_valid = 1'b0;
        check("post_rst_early", if_def.out_valid, 0);
        tick();
        check("post_rst_vld", if_def.out_valid, 1);
        check("post_rst_d",   if_def.dout, 4);
        tick();
        tick();
        tick();

        // Random sweep: 1-stage and 4-stage builds, exact latency 1 and 4
        for (int i = 0; i < N_RAND; i++) begin
            ra[i] = int'($urandom_range(0, 65535)) - 32768;
            rb[i] = int'($urandom_range(0, 1023)) - 512;
        end
        for (int i = 0; i < N_RAND + 3; i++) begin
            if (i < N_RAND) drive(ra[i], rb[i]);
            else            in_valid = 1'b0;
            tick();
            if (i < N_RAND) begin
                check($sformatf("rnd_s1_vld%0d", i), if_s1.out_valid, 1);
                check($sformatf("rnd_s1_%0d", i),    if_s1.dout, mdl(ra[i], rb[i]));
            end
            if (i >= 3) begin
                check($sformatf("rnd_s4_vld%0d", i-3), if_s4.out_valid, 1);
                check($sformatf("rnd_s4_%0d", i-3),    if_s4.dout, mdl(ra[i-3], rb[i-3]));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_hls_mul_pipe.md
Name: fir_hls_mul_pipe

Overview:
Parametrised, pipelined signed multiplier for the FIR datapath. It is the successor to the single-cycle combinational coefficient multiplier. It adds configurable pipeline depth, a valid/ready handshake with backpressure, and optional output scaling (arithmetic right shift with truncate or round). It also adds saturation to the output width and a sticky overflow flag. It sits between the tap/coefficient fetch and the accumulator in each FIR lane.

Parameters:
DIN0_WIDTH, 16, signed sample operand width (>=2)
DIN1_WIDTH, 10, signed coefficient operand width (>=2)
DOUT_WIDTH, 25, signed result width (>=2)
NUM_STAGE, 2, register stages from accepted input to out_valid (1..4)
SHIFT, 0, arithmetic right shift applied to full product (0..DIN0_WIDTH+DIN1_WIDTH-2)
ROUND_EN, 0, 0 = truncate toward -inf; 1 = round half up (add 2^(SHIFT-1) before shift; ignored if SHIFT=0)
SAT_EN, 0, 0 = wrap (keep low DOUT_WIDTH bits); 1 = clamp to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]

Ports:
ap_clk  in  1  clock, all logic on rising edge
ap_rst_n  in  1  synchronous reset, active low
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
din0  in  DIN0_WIDTH  signed sample
din1  in  DIN1_WIDTH  signed coefficient
out_valid  out  1  dout holds a result
out_ready  in  1  downstream accepts dout this cycle
dout  out  DOUT_WIDTH  signed scaled result
ovf  out  1  sticky: some result exceeded DOUT_WIDTH range (independent of SAT_EN)
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (ap_rst_n=0 at edge): all stage valid bits, out_valid, dout and ovf are set to 0. In-flight data is discarded. Reset takes priority over every other input.
- Global advance: adv = out_ready | ~out_valid. in_ready = adv, combinational from out_ready (documented path).
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- When adv=1, every stage register loads from its predecessor. Stage-0 valid loads in_valid. When adv=0, all stages hold. Bubbles are not compressed.
- Latency: exactly NUM_STAGE cycles from input transfer to out_valid with no backpressure. Throughput is 1 result/cycle.
- Stage 1 registers the full product P = din0*din1, width DIN0_WIDTH+DIN1_WIDTH, exact and signed.
- The final stage computes R = (P + (ROUND_EN&&SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT.
  - The add uses one guard bit, so it never wraps.
  - R then saturates or wraps into dout.
- If NUM_STAGE=1, product and scaling occur in a single registered stage.
- Extra stages (NUM_STAGE>2) are pure delay registers placed after the product register.
- Overflow: when a result leaves the final stage with R outside the DOUT_WIDTH signed range, ovf is set on the same edge that dout loads.
  - ovf_clr and a same-cycle new overflow: set wins, so ovf=1.
  - ovf_clr alone clears ovf on the next edge.
- dout holds its value while out_valid=1 & out_ready=0. dout is don't-care-stable (holds last value) when out_valid=0.
- Reset asserted mid-stream: next cycle out_valid=0 and in_ready=1. The first post-reset result appears NUM_STAGE cycles after the next input transfer.

Test Plan:
- Defaults, stream din0=1000,din1=-3 then 7,5 with out_ready=1 -> dout=-3000 at cycle +2, 35 at cycle +3, ovf=0.
- Defaults, din0=-32768,din1=-512 -> R=16777216; SAT_EN=0: dout=-16777216, ovf=1. SAT_EN=1: dout=16777215, ovf=1. Then ovf_clr pulse -> ovf=0.
- SHIFT=4: 100*3=300 -> ROUND_EN=0 gives 18, ROUND_EN=1 gives 19. -100*3=-300 -> truncate gives -19, round gives -19. -8*1 with round gives 0.
- Backpressure: 4 back-to-back inputs, out_ready=0 for 3 cycles after first out_valid -> in_ready=0 during stall, dout held, all 4 results emitted in order with none lost or duplicated.
- ap_rst_n low for 1 cycle with 2 results in flight -> out_valid=0, ovf=0 next cycle. No stale result is ever emitted.
- NUM_STAGE=1 and NUM_STAGE=4 sweep with 1000 random operands against a reference model -> exact match, latency 1 and 4 respectively.
